// File: rtl/ifmap_read_sequencer_pkg.sv
// Shared accelerator definitions for the ifmap read sequencer: sequencer states,
// default counter widths and the bit layout of the packed configuration word.
package ifmap_read_sequencer_pkg;

  localparam int DEF_COUNT_WIDTH = 24;
  localparam int DEF_TILE_WIDTH  = 16;

  // NUM_TILES sits in the low bits of config_data; READS_PER_TILE sits directly above it.
  localparam int CFG_TILES_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BANK = 2'd1,
    ST_READ      = 2'd2,
    ST_DRAIN     = 2'd3
  } seq_state_e;

  function automatic int cfg_reads_lsb(input int tile_width);
    return CFG_TILES_LSB + tile_width;
  endfunction

endpackage

// File: rtl/ifmap_read_sequencer.sv
// Paces ifmap buffer reads tile by tile: adr_en is combinational, rd_valid/tile_last follow one cycle later.
// A stall holds the sequencer in READ; an empty bank holds it in WAIT_BANK with adr_en low.
module ifmap_read_sequencer
  import ifmap_read_sequencer_pkg::*;
#(
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int TILE_WIDTH  = DEF_TILE_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              config_en,
  input  logic [COUNT_WIDTH+TILE_WIDTH-1:0] config_data,
  input  logic                              start,
  input  logic                              bank_ready,
  input  logic                              stall,
  output logic                              adr_en,
  output logic                              rd_valid,
  output logic                              tile_last,
  output logic                              bank_release,
  output logic                              busy,
  output logic                              done
);

  localparam int READS_LSB = cfg_reads_lsb(TILE_WIDTH);

  seq_state_e             state_q, state_d;
  logic [COUNT_WIDTH-1:0] cfg_reads_q, cfg_reads_d;
  logic [TILE_WIDTH-1:0]  cfg_tiles_q, cfg_tiles_d;
  logic [COUNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [TILE_WIDTH-1:0]  tile_cnt_q, tile_cnt_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   tile_last_q, tile_last_d;
  logic                   done_q, done_d;

  logic [COUNT_WIDTH-1:0] reads_last;
  logic [TILE_WIDTH-1:0]  tiles_last;
  logic                   final_read;

  assign reads_last = cfg_reads_q - COUNT_WIDTH'(1);
  assign tiles_last = cfg_tiles_q - TILE_WIDTH'(1);
  assign adr_en     = (state_q == ST_READ) && !stall;
  assign final_read = adr_en && (rd_cnt_q == reads_last);

  always_comb begin
    state_d     = state_q;
    cfg_reads_d = cfg_reads_q;
    cfg_tiles_d = cfg_tiles_q;
    rd_cnt_d    = rd_cnt_q;
    tile_cnt_d  = tile_cnt_q;
    done_d      = 1'b0;
    rd_valid_d  = adr_en;
    tile_last_d = final_read;

    unique case (state_q)
      ST_IDLE: begin
        // A start that coincides with a config load is dropped; the load still happens.
        if (config_en) begin
          cfg_reads_d = config_data[READS_LSB +: COUNT_WIDTH];
          cfg_tiles_d = config_data[CFG_TILES_LSB +: TILE_WIDTH];
        end else if (start) begin
          if ((|cfg_reads_q) && (|cfg_tiles_q)) begin
            state_d    = ST_WAIT_BANK;
            rd_cnt_d   = '0;
            tile_cnt_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_WAIT_BANK: begin
        if (bank_ready) state_d = ST_READ;
      end
      ST_READ: begin
        if (final_read) begin
          rd_cnt_d = '0;
          state_d  = ST_DRAIN;
        end else if (adr_en) begin
          rd_cnt_d = rd_cnt_q + COUNT_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        if (tile_cnt_q == tiles_last) begin
          tile_cnt_d = '0;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          tile_cnt_d = tile_cnt_q + TILE_WIDTH'(1);
          state_d    = ST_WAIT_BANK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cfg_reads_q <= '0;
      cfg_tiles_q <= '0;
      rd_cnt_q    <= '0;
      tile_cnt_q  <= '0;
      rd_valid_q  <= 1'b0;
      tile_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_reads_q <= cfg_reads_d;
      cfg_tiles_q <= cfg_tiles_d;
      rd_cnt_q    <= rd_cnt_d;
      tile_cnt_q  <= tile_cnt_d;
      rd_valid_q  <= rd_valid_d;
      tile_last_q <= tile_last_d;
      done_q      <= done_d;
    end
  end

  assign rd_valid     = rd_valid_q;
  assign tile_last    = tile_last_q;
  assign bank_release = (state_q == ST_DRAIN);
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;

endmodule
